// File: rtl/instruction_assembler_if.sv
// Packet handshake between the instruction assembler and the execution unit.
// The master drives the assembled packet and the slave returns insn_ready.
interface instruction_assembler_if;
  logic        insn_valid;
  logic        insn_ready;
  logic [15:0] insn_pc;
  logic [3:0]  insn_len;
  logic [7:0]  insn_opcode;
  logic [7:0]  insn_modrm;
  logic [15:0] insn_disp;
  logic [15:0] insn_imm;
  logic [2:0]  insn_seg_ovr;
  logic [1:0]  insn_rep;
  logic        insn_lock;

  modport master (
    output insn_valid,
    output insn_pc,
    output insn_len,
    output insn_opcode,
    output insn_modrm,
    output insn_disp,
    output insn_imm,
    output insn_seg_ovr,
    output insn_rep,
    output insn_lock,
    input  insn_ready
  );

  modport slave (
    input  insn_valid,
    input  insn_pc,
    input  insn_len,
    input  insn_opcode,
    input  insn_modrm,
    input  insn_disp,
    input  insn_imm,
    input  insn_seg_ovr,
    input  insn_rep,
    input  insn_lock,
    output insn_ready
  );
endinterface

// File: rtl/instruction_assembler.sv
// Pulls bytes from the prefetch queue one per ce_1 and assembles prefixes, opcode, ModRM,
// displacement and immediate into a packet for the execution unit; owns the fetch pointer.
module instruction_assembler #(
  parameter logic [15:0] RESET_IP = 16'h0000,
  parameter logic [3:0]  MAX_LEN  = 4'd15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce_1,
  input  logic [7:0][7:0]         ipq,
  input  logic [3:0]              ipq_len,
  output logic [15:0]             ipq_head,
  output logic                    pfp_set,
  output logic [7:0]              op_byte,
  input  logic                    op_has_modrm,
  input  logic [1:0]              op_imm_bytes,
  input  logic                    branch_req,
  input  logic [15:0]             branch_target,
  instruction_assembler_if.master insn
);

  localparam logic [2:0] StOpcode = 3'd0;
  localparam logic [2:0] StModrm  = 3'd1;
  localparam logic [2:0] StDispLo = 3'd2;
  localparam logic [2:0] StDispHi = 3'd3;
  localparam logic [2:0] StImmLo  = 3'd4;
  localparam logic [2:0] StImmHi  = 3'd5;
  localparam logic [2:0] StHold   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] head_q, head_d;
  logic        pfp_q, pfp_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [15:0] pc_q, pc_d;
  logic [3:0]  len_q, len_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  modrm_q, modrm_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] imm_q, imm_d;
  logic [2:0]  seg_q, seg_d;
  logic [1:0]  rep_q, rep_d;
  logic        lock_q, lock_d;
  logic [1:0]  imm_sz_q, imm_sz_d;
  logic [1:0]  disp_sz_q, disp_sz_d;

  logic [7:0]  byte_in;
  logic        take;
  logic [1:0]  op_imm_sz;
  logic [1:0]  modrm_disp_sz;
  logic [3:0]  len_sat;
  logic [2:0]  after_disp;

  assign byte_in = ipq[head_q[2:0]];
  assign op_byte = byte_in;

  // The cycle after a redirect the BCU is still refilling, so nothing is consumed.
  assign take = ce_1 && !branch_req && !pfp_q && (ipq_len != 4'd0) && (state_q != StHold);

  assign op_imm_sz = (op_imm_bytes == 2'd3) ? 2'd2 : op_imm_bytes;
  assign len_sat   = (len_q >= MAX_LEN) ? MAX_LEN : len_q + 4'd1;
  assign after_disp = (imm_sz_q != 2'd0) ? StImmLo : StHold;

  always_comb begin
    modrm_disp_sz = 2'd0;
    unique case (byte_in[7:6])
      2'b01:   modrm_disp_sz = 2'd1;
      2'b10:   modrm_disp_sz = 2'd2;
      2'b00:   modrm_disp_sz = (byte_in[2:0] == 3'b110) ? 2'd2 : 2'd0;
      default: modrm_disp_sz = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    pfp_d     = pfp_q;
    valid_d   = valid_q;
    first_d   = first_q;
    pc_d      = pc_q;
    len_d     = len_q;
    opcode_d  = opcode_q;
    modrm_d   = modrm_q;
    disp_d    = disp_q;
    imm_d     = imm_q;
    seg_d     = seg_q;
    rep_d     = rep_q;
    lock_d    = lock_q;
    imm_sz_d  = imm_sz_q;
    disp_sz_d = disp_sz_q;

    if (ce_1) begin
      pfp_d = 1'b0;
      if (branch_req) begin
        head_d  = branch_target;
        pfp_d   = 1'b1;
        valid_d = 1'b0;
        state_d = StOpcode;
        first_d = 1'b1;
      end else if (state_q == StHold) begin
        if (insn.insn_ready) begin
          valid_d = 1'b0;
          state_d = StOpcode;
          first_d = 1'b1;
        end
      end else if (take) begin
        head_d = head_q + 16'd1;
        len_d  = first_q ? 4'd1 : len_sat;
        case (state_q)
          StOpcode: begin
            // Previous packet fields stay visible until a new instruction starts.
            if (first_q) begin
              pc_d     = head_q;
              seg_d    = 3'b000;
              rep_d    = 2'b00;
              lock_d   = 1'b0;
              opcode_d = 8'h00;
              modrm_d  = 8'h00;
              disp_d   = 16'h0000;
              imm_d    = 16'h0000;
            end
            first_d = 1'b0;
            case (byte_in)
              8'h26: seg_d  = 3'b100;
              8'h2E: seg_d  = 3'b101;
              8'h36: seg_d  = 3'b110;
              8'h3E: seg_d  = 3'b111;
              8'hF0: lock_d = 1'b1;
              8'hF2: rep_d  = 2'b10;
              8'hF3: rep_d  = 2'b11;
              default: begin
                opcode_d  = byte_in;
                imm_sz_d  = op_imm_sz;
                disp_sz_d = 2'd0;
                if (op_has_modrm) begin
                  state_d = StModrm;
                end else if (op_imm_sz != 2'd0) begin
                  state_d = StImmLo;
                end else begin
                  state_d = StHold;
                end
              end
            endcase
          end
          StModrm: begin
            modrm_d   = byte_in;
            disp_sz_d = modrm_disp_sz;
            state_d   = (modrm_disp_sz != 2'd0) ? StDispLo : after_disp;
          end
          StDispLo: begin
            disp_d  = {{8{byte_in[7]}}, byte_in};
            state_d = (disp_sz_q == 2'd2) ? StDispHi : after_disp;
          end
          StDispHi: begin
            disp_d  = {byte_in, disp_q[7:0]};
            state_d = after_disp;
          end
          StImmLo: begin
            imm_d   = {8'h00, byte_in};
            state_d = (imm_sz_q == 2'd2) ? StImmHi : StHold;
          end
          StImmHi: begin
            imm_d   = {byte_in, imm_q[7:0]};
            state_d = StHold;
          end
          default: state_d = StOpcode;
        endcase
        valid_d = (state_d == StHold);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StOpcode;
      head_q    <= RESET_IP;
      pfp_q     <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b1;
      pc_q      <= 16'h0000;
      len_q     <= 4'd0;
      opcode_q  <= 8'h00;
      modrm_q   <= 8'h00;
      disp_q    <= 16'h0000;
      imm_q     <= 16'h0000;
      seg_q     <= 3'b000;
      rep_q     <= 2'b00;
      lock_q    <= 1'b0;
      imm_sz_q  <= 2'd0;
      disp_sz_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      pfp_q     <= pfp_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      opcode_q  <= opcode_d;
      modrm_q   <= modrm_d;
      disp_q    <= disp_d;
      imm_q     <= imm_d;
      seg_q     <= seg_d;
      rep_q     <= rep_d;
      lock_q    <= lock_d;
      imm_sz_q  <= imm_sz_d;
      disp_sz_q <= disp_sz_d;
    end
  end

  assign ipq_head          = head_q;
  assign pfp_set           = pfp_q;
  assign insn.insn_valid   = valid_q;
  assign insn.insn_pc      = pc_q;
  assign insn.insn_len     = len_q;
  assign insn.insn_opcode  = opcode_q;
  assign insn.insn_modrm   = modrm_q;
  assign insn.insn_disp    = disp_q;
  assign insn.insn_imm     = imm_q;
  assign insn.insn_seg_ovr = seg_q;
  assign insn.insn_rep     = rep_q;
  assign insn.insn_lock    = lock_q;

endmodule
